// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline stage with a two-entry skid buffer, synchronous flush and a forwarding tap.
// state | meaning: EMPTY | no bundle held; ONE | main entry valid; FULL | main and skid valid.
module ex_mem_stage_buf #(
  parameter int DATA_W  = 20,
  parameter int RF_W    = 16,
  parameter int OP_W    = 4,
  parameter int INSTR_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               alu_zero,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [RF_W-1:0]    read_data2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    opcode_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               alu_zero_out,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  data_rf_out2,
  output logic               fwd_valid,
  output logic [DATA_W-1:0]  fwd_result
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t               state;
  logic                 main_valid;
  logic [OP_W-1:0]      skid_opcode;
  logic [INSTR_W-1:0]   skid_instr;
  logic                 skid_zero;
  logic [DATA_W-1:0]    skid_result;
  logic [DATA_W-1:0]    skid_rd2;
  logic [DATA_W-1:0]    rd2_ext;
  logic                 accept;
  logic                 drain;

  assign rd2_ext    = DATA_W'(read_data2);
  assign accept     = in_valid & in_ready;
  assign drain      = main_valid & out_ready;
  assign out_valid  = main_valid;
  assign fwd_valid  = main_valid;
  assign fwd_result = alu_result_out;

  // in_ready is its own flop, set from the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state           <= EMPTY;
      main_valid      <= 1'b0;
      in_ready        <= 1'b1;
      opcode_out      <= '0;
      instruction_out <= '0;
      alu_zero_out    <= 1'b0;
      alu_result_out  <= '0;
      data_rf_out2    <= '0;
      skid_opcode     <= '0;
      skid_instr      <= '0;
      skid_zero       <= 1'b0;
      skid_result     <= '0;
      skid_rd2        <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            opcode_out      <= opcode;
            instruction_out <= instruction;
            alu_zero_out    <= alu_zero;
            alu_result_out  <= alu_result;
            data_rf_out2    <= rd2_ext;
            main_valid      <= 1'b1;
            state           <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            opcode_out      <= opcode;
            instruction_out <= instruction;
            alu_zero_out    <= alu_zero;
            alu_result_out  <= alu_result;
            data_rf_out2    <= rd2_ext;
          end else if (drain) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end else if (accept) begin
            skid_opcode <= opcode;
            skid_instr  <= instruction;
            skid_zero   <= alu_zero;
            skid_result <= alu_result;
            skid_rd2    <= rd2_ext;
            in_ready    <= 1'b0;
            state       <= FULL;
          end
        end
        FULL: begin
          if (drain) begin
            opcode_out      <= skid_opcode;
            instruction_out <= skid_instr;
            alu_zero_out    <= skid_zero;
            alu_result_out  <= skid_result;
            data_rf_out2    <= skid_rd2;
            skid_opcode     <= '0;
            skid_instr      <= '0;
            skid_zero       <= 1'b0;
            skid_result     <= '0;
            skid_rd2        <= '0;
            in_ready        <= 1'b1;
            state           <= ONE;
          end
        end
        default: begin
          main_valid <= 1'b0;
          in_ready   <= 1'b1;
          state      <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Scoreboard bench for ex_mem_stage_buf: default widths with directed vectors, plus a 32-bit instance under random handshakes.
module tb_ex_mem_stage_buf;

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] ins;
    logic [31:0] res;
    logic [31:0] rd2;
    logic        z;
  } bund_t;

  int checks = 0;
  int failures = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // default-width instance
  logic        reset, flush, in_valid, in_ready, alu_zero, out_valid, out_ready, alu_zero_out, fwd_valid;
  logic [3:0]  opcode, opcode_out;
  logic [19:0] instruction, instruction_out, alu_result, alu_result_out, data_rf_out2, fwd_result;
  logic [15:0] read_data2;

  ex_mem_stage_buf dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .instruction(instruction), .alu_zero(alu_zero), .alu_result(alu_result),
    .read_data2(read_data2), .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
    .instruction_out(instruction_out), .alu_zero_out(alu_zero_out), .alu_result_out(alu_result_out),
    .data_rf_out2(data_rf_out2), .fwd_valid(fwd_valid), .fwd_result(fwd_result)
  );

  // wide instance
  logic        reset_b, flush_b, in_valid_b, in_ready_b, alu_zero_b, out_valid_b, out_ready_b, alu_zero_out_b, fwd_valid_b;
  logic [5:0]  opcode_b, opcode_out_b;
  logic [31:0] instruction_b, instruction_out_b, alu_result_b, alu_result_out_b, data_rf_out2_b, fwd_result_b, read_data2_b;

  ex_mem_stage_buf #(.DATA_W(32), .RF_W(32), .OP_W(6), .INSTR_W(32)) dut_b (
    .clock(clock), .reset(reset_b), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .opcode(opcode_b), .instruction(instruction_b), .alu_zero(alu_zero_b), .alu_result(alu_result_b),
    .read_data2(read_data2_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .opcode_out(opcode_out_b),
    .instruction_out(instruction_out_b), .alu_zero_out(alu_zero_out_b), .alu_result_out(alu_result_out_b),
    .data_rf_out2(data_rf_out2_b), .fwd_valid(fwd_valid_b), .fwd_result(fwd_result_b)
  );

  bund_t q1[$];
  bund_t q2[$];
  bit    chk1 = 0;
  bit    chk2 = 0;
  int    acc2 = 0;
  int    drn2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bundle(input string tag, input bund_t e, input bund_t a);
    chk({tag, "_opcode"}, a.op, e.op);
    chk({tag, "_instr"}, a.ins, e.ins);
    chk({tag, "_result"}, a.res, e.res);
    chk({tag, "_rd2"}, a.rd2, e.rd2);
    chk({tag, "_zero"}, 32'(a.z), 32'(e.z));
  endtask

  // monitor for the default instance; occupancy model: held bundles = queue depth
  always @(negedge clock) begin
    bund_t e, a;
    if (chk1) begin
      chk("out_valid", 32'(out_valid), 32'(q1.size() > 0));
      chk("fwd_valid", 32'(fwd_valid), 32'(q1.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q1.size() < 2));
      if (out_valid === 1'b1 && out_ready) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out actual=%0h required=none", alu_result_out);
        end else begin
          e = q1.pop_front();
          a.op = 32'(opcode_out); a.ins = 32'(instruction_out); a.res = 32'(alu_result_out);
          a.rd2 = 32'(data_rf_out2); a.z = alu_zero_out;
          chk_bundle("out", e, a);
          chk("fwd_result", 32'(fwd_result), e.res);
        end
      end
    end
    if (reset || flush) q1.delete();
    else if (in_valid && in_ready === 1'b1) begin
      e.op = 32'(opcode); e.ins = 32'(instruction); e.res = 32'(alu_result);
      e.rd2 = {16'h0000, read_data2}; e.z = alu_zero;
      q1.push_back(e);
    end
  end

  always @(negedge clock) begin
    bund_t e, a;
    if (chk2) begin
      chk("b_out_valid", 32'(out_valid_b), 32'(q2.size() > 0));
      chk("b_in_ready", 32'(in_ready_b), 32'(q2.size() < 2));
      if (out_valid_b === 1'b1 && out_ready_b) begin
        drn2++;
        if (q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_out actual=%0h required=none", alu_result_out_b);
        end else begin
          e = q2.pop_front();
          a.op = 32'(opcode_out_b); a.ins = instruction_out_b; a.res = alu_result_out_b;
          a.rd2 = data_rf_out2_b; a.z = alu_zero_out_b;
          chk_bundle("b_out", e, a);
          chk("b_fwd_result", fwd_result_b, e.res);
        end
      end
    end
    if (reset_b || flush_b) q2.delete();
    else if (in_valid_b && in_ready_b === 1'b1) begin
      acc2++;
      e.op = 32'(opcode_b); e.ins = instruction_b; e.res = alu_result_b; e.rd2 = read_data2_b; e.z = alu_zero_b;
      q2.push_back(e);
    end
  end

  task automatic send(input logic v, input logic [3:0] op, input logic [19:0] ins, input logic z,
                      input logic [19:0] res, input logic [15:0] rd2, input logic ordy, input logic fl);
    @(posedge clock); #1;
    in_valid = v; opcode = op; instruction = ins; alu_zero = z; alu_result = res;
    read_data2 = rd2; out_ready = ordy; flush = fl;
  endtask

  task automatic idle(input logic ordy);
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = ordy;
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_opcode0"}, 32'(opcode_out), 32'h0);
    chk({tag, "_instr0"}, 32'(instruction_out), 32'h0);
    chk({tag, "_zero0"}, 32'(alu_zero_out), 32'h0);
    chk({tag, "_result0"}, 32'(alu_result_out), 32'h0);
    chk({tag, "_rd2_0"}, 32'(data_rf_out2), 32'h0);
    chk({tag, "_fwd0"}, 32'(fwd_result), 32'h0);
    chk({tag, "_valid0"}, 32'(out_valid), 32'h0);
    chk({tag, "_ready1"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    opcode = 4'h9; instruction = 20'hABCDE; alu_zero = 1'b1; alu_result = 20'h12345; read_data2 = 16'h5555;
    reset_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    opcode_b = '0; instruction_b = '0; alu_zero_b = 1'b0; alu_result_b = '0; read_data2_b = '0;

    // reset held two cycles while a bundle is offered
    @(posedge clock); #1; chk1 = 1;
    @(posedge clock); #1; reset = 1'b0; in_valid = 1'b0;
    @(negedge clock); zero_checks("reset");

    // first accept after reset, then streaming at full rate
    for (int i = 1; i <= 5; i++)
      send(1'b1, 4'(i), 20'h10000 + 20'(i), 1'b0, 20'(i), 16'h1000 + 16'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // stall: A then B with MEM not ready; outputs hold A, skid fills
    send(1'b1, 4'h3, 20'h0A0A0, 1'b0, 20'h0000A, 16'h000A, 1'b0, 1'b0);
    send(1'b1, 4'h4, 20'h0B0B0, 1'b0, 20'h0000B, 16'h000B, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    @(negedge clock);
    chk("stall_hold", 32'(alu_result_out), 32'h0000A);
    chk("stall_ready", 32'(in_ready), 32'h0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // zero-extension of operand 2 and zero-flag propagation
    send(1'b1, 4'hF, 20'hFFFFF, 1'b1, 20'h00000, 16'hFFFF, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clock);
    chk("zext_rd2", 32'(data_rf_out2), 32'h0FFFF);
    chk("zero_flag", 32'(alu_zero_out), 32'h1);
    idle(1'b1);
    idle(1'b0);

    // flush while FULL with a bundle offered; it must never appear
    send(1'b1, 4'h1, 20'h11111, 1'b0, 20'h00111, 16'h0111, 1'b0, 1'b0);
    send(1'b1, 4'h2, 20'h22222, 1'b0, 20'h00222, 16'h0222, 1'b0, 1'b0);
    idle(1'b0);
    send(1'b1, 4'h7, 20'h77777, 1'b1, 20'h00777, 16'h0777, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clock); zero_checks("flush");
    idle(1'b1);
    idle(1'b1);

    // flush together with a drain: MEM still takes the bundle, stage ends EMPTY
    send(1'b1, 4'h5, 20'h55555, 1'b0, 20'h00555, 16'h0555, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clock); #1; flush = 1'b1; out_ready = 1'b1;
    idle(1'b1);
    @(negedge clock); zero_checks("flush_drain");

    // wide instance, random handshakes
    @(posedge clock); #1; chk2 = 1; reset_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      in_valid_b = 1'($urandom_range(0, 1)); out_ready_b = 1'($urandom_range(0, 1));
      opcode_b = 6'($urandom); instruction_b = $urandom; alu_zero_b = 1'($urandom);
      alu_result_b = $urandom; read_data2_b = $urandom;
    end
    @(posedge clock); #1; in_valid_b = 1'b0; out_ready_b = 1'b1;
    for (int i = 0; i < 10 && q2.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    chk("sweep_drained", 32'(q2.size()), 32'h0);
    chk("sweep_count", 32'(drn2), 32'(acc2));
    chk("sweep_nonzero", 32'(acc2 > 20), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_buf.md
# ex_mem_stage_buf

Parametrised EX/MEM pipeline stage for the pipelined processor: captures the execute-stage results (ALU result, ALU zero flag, register-file operand 2, opcode, full instruction word) and presents them to the memory stage. It is the successor of the plain clocked EX/MEM register. It adds a valid/ready handshake with a two-entry skid buffer so the memory stage can stall without combinational ready paths, a synchronous flush for branch/jump squash, and a registered forwarding tap for the hazard unit. All fields, including the instruction word, are registered.

## Interface
Parameters:
- DATA_W, 20, width of ALU result and stored operand-2 path
- RF_W, 16, width of register-file read port 2 (RF_W ≤ DATA_W)
- OP_W, 4, opcode width
- INSTR_W, 20, instruction word width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous squash of every held entry
- in_valid  in  1  EX stage presents a bundle
- in_ready  out  1  stage can accept; registered
- opcode  in  OP_W  EX opcode
- instruction  in  INSTR_W  EX instruction word
- alu_zero  in  1  ALU zero flag
- alu_result  in  DATA_W  ALU result
- read_data2  in  RF_W  register-file operand 2
- out_valid  out  1  MEM-stage bundle valid
- out_ready  in  1  MEM stage consumes bundle
- opcode_out  out  OP_W  registered opcode
- instruction_out  out  INSTR_W  registered instruction
- alu_zero_out  out  1  registered zero flag
- alu_result_out  out  DATA_W  registered ALU result
- data_rf_out2  out  DATA_W  read_data2 zero-extended to DATA_W
- fwd_valid  out  1  equals out_valid; forwarding tap
- fwd_result  out  DATA_W  equals alu_result_out

## Operation
- Storage: main entry (drives outputs) plus one skid entry; each has a valid bit and a full payload copy.
- States: EMPTY (neither valid), ONE (main valid), FULL (main + skid valid). in_ready = !skid_valid.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept → load main, go ONE.
- ONE: accept & drain → load main with new input, stay ONE. Drain only → EMPTY. Accept only → load skid, go FULL. Neither → hold.
- FULL: in_ready=0, input ignored. Drain → skid moves to main, skid cleared, go ONE. No drain → hold.
- Payload order is strictly FIFO; no bundle is duplicated or lost without flush/reset.
- read_data2 is zero-extended: upper DATA_W−RF_W bits of data_rf_out2 are 0.
- flush: next state EMPTY, both valid bits 0, all payload registers cleared to 0. An input offered in the flush cycle is dropped, even if in_ready=1. flush has priority over accept and drain.
- reset: same effect as flush and has highest priority. Every output is 0 after reset except in_ready, which is 1.
- Payload registers update only on load; they hold their value while their entry is valid and not draining.

## Timing
- Latency: an accept at edge N gives out_valid=1 with the payload after edge N (visible in cycle N+1).
- Throughput: 1 bundle/cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready. Deasserts the cycle after the skid fills. Reasserts the cycle after the drain from FULL.
- out_valid and all payload outputs come directly from flops.
- Reset or flush asserted mid-stall (FULL): the cycle after, out_valid=0, in_ready=1, payload outputs 0.
- Simultaneous flush and out_ready: the drain completes downstream (MEM samples the current outputs) and the stage still becomes EMPTY.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, in_ready=1, all payloads 0. First accept after release appears 1 cycle later.
- Streaming: out_ready=1, send alu_result 0x00001..0x00005, one per cycle → out_valid continuous, values in order, each 1 cycle late, in_ready never 0.
- Stall/skid: out_ready=0, send A=0x0000A then B=0x0000B → in_ready=0 after B, outputs hold A. Raise out_ready → A then B drain, in_ready=1 one cycle after A drains.
- Zero-extend: RF_W=16, DATA_W=20, read_data2=0xFFFF → data_rf_out2=0x0FFFF. alu_zero=1 propagates to alu_zero_out=1.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, payloads 0, offered bundle never appears.
- Parameter sweep: DATA_W=32, RF_W=32, OP_W=6, INSTR_W=32 with random valid/ready → scoreboard matches FIFO order, no loss or duplication.
